mux_rr_n: RTL and testbench

- Registered N-channel, W-bit multiplexer with valid/ready handshake on every input and on the output.
- Generalises the team's 2:1 combinational muxes in three ways: any channel count, any data width, and a runtime mode bit.
- Mode bit selects between fixed (sel-driven) selection and round-robin arbitration.
- Sits between multiple producer blocks and a single shared consumer datapath.

---
 rtl/mux_rr_n.sv | 91 +++++++++
 tb/tb_mux_rr_n.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_n.sv
// mux_rr_n: registered N-channel, W-bit multiplexer with valid/ready on
// every input and on the output. A runtime mode bit chooses between a
// sel-driven fixed pick (mode=0) and round-robin arbitration (mode=1).
// The output stage is a pass-through register: a word can be popped and
// replaced in the same cycle, so a steady stream moves one word per clock.
module mux_rr_n #(
    parameter int WIDTH = 4,
    parameter int N_CH  = 4,
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_CH*WIDTH-1:0]   in_data,
    input  logic [N_CH-1:0]         in_valid,
    output logic [N_CH-1:0]         in_ready,
    input  logic                    mode,
    input  logic [CH_W-1:0]         sel,
    output logic [WIDTH-1:0]        mux_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CH_W-1:0]         out_ch
);

    logic [CH_W-1:0] rr_ptr;
    logic [CH_W-1:0] cand;
    logic            cand_found;
    logic            load_en;
    logic            grant;

    // The output register can take a new word when empty or being popped.
    assign load_en = !out_valid || out_ready;
    assign grant   = !reset && load_en && cand_found;

    // Candidate search: direct index in fixed mode, rotating scan from
    // rr_ptr in round-robin mode. An out-of-range sel yields no candidate.
    always_comb begin
        int sel_i;
        int idx;
        cand       = '0;
        cand_found = 1'b0;
        sel_i      = int'(sel);
        idx        = 0;
        if (!mode) begin
            if (sel_i < N_CH) begin
                if (in_valid[sel_i]) begin
                    cand       = sel;
                    cand_found = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                idx = int'(rr_ptr) + i;
                if (idx >= N_CH) begin
                    idx = idx - N_CH;
                end
                if (!cand_found && in_valid[idx]) begin
                    cand       = CH_W'(idx);
                    cand_found = 1'b1;
                end
            end
        end
    end

    // One-hot ready toward the granted producer only; zero during reset.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N_CH; i++) begin
            in_ready[i] = grant && (cand == CH_W'(i));
        end
    end

    // Output register and round-robin pointer update.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            mux_out   <= '0;
            out_ch    <= '0;
            rr_ptr    <= '0;
        end else if (grant) begin
            out_valid <= 1'b1;
            mux_out   <= in_data[cand*WIDTH +: WIDTH];
            out_ch    <= cand;
            if (mode) begin
                rr_ptr <= (cand == CH_W'(N_CH - 1)) ? '0 : cand + 1'b1;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_rr_n.sv
// tb_mux_rr_n: directed scenarios for mux_rr_n. The main instance has
// four channels; a second three-channel instance covers an out-of-range sel.
module tb_mux_rr_n;

    logic        clk = 1'b0;
    logic        reset;

    logic [15:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  mux_out;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_ch;

    logic [11:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic        mode3;
    logic [1:0]  sel3;
    logic [3:0]  mux_out3;
    logic        out_valid3;
    logic        out_ready3;
    logic [1:0]  out_ch3;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    mux_rr_n #(.WIDTH(4), .N_CH(4)) u_dut4 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .sel(sel), .mux_out(mux_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch)
    );

    mux_rr_n #(.WIDTH(4), .N_CH(3)) u_dut3 (
        .clk(clk), .reset(reset), .in_data(in_data3), .in_valid(in_valid3),
        .in_ready(in_ready3), .mode(mode3), .sel(sel3), .mux_out(mux_out3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_ch(out_ch3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string name, input logic v, input logic [3:0] d,
                           input logic [1:0] ch);
        nvec++;
        if (out_valid !== v || mux_out !== d || out_ch !== ch) begin
            nerr++;
            $display("FAIL %s actual v=%b d=%h ch=%0d expected v=%b d=%h ch=%0d",
                     name, out_valid, mux_out, out_ch, v, d, ch);
        end
    endtask

    task automatic chk_rdy(input string name, input logic [3:0] exp);
        nvec++;
        if (in_ready !== exp) begin
            nerr++;
            $display("FAIL %s in_ready actual=%b expected=%b", name, in_ready, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            chk_out("reset_out", 1'b0, 4'h0, 2'd0);
            chk_rdy("reset_rdy", 4'b0000);
        end
        reset = 1'b0;
        #1;
        chk_rdy("reset_first_grant", 4'b0001);
    endtask

    task automatic test_round_robin();
        for (int k = 0; k < 6; k++) begin
            step();
            chk_out("rr_seq", 1'b1, 4'(4'hA + (k % 4)), 2'(k % 4));
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        #1;
        chk_rdy("bp_stall_rdy0", 4'b0000);
        for (int k = 0; k < 3; k++) begin
            step();
            chk_out("bp_hold", 1'b1, 4'hB, 2'd1);
            chk_rdy("bp_stall_rdy", 4'b0000);
        end
        out_ready = 1'b1;
        #1;
        chk_rdy("bp_release_rdy", 4'b0100);
        step();
        chk_out("bp_next", 1'b1, 4'hC, 2'd2);
        step();
        chk_out("bp_next2", 1'b1, 4'hD, 2'd3);
    endtask

    task automatic test_fixed();
        mode = 1'b0; sel = 2'd2; in_valid = 4'b0100;
        in_data = {4'hD, 4'h7, 4'hB, 4'hA};
        #1;
        chk_rdy("fix_rdy", 4'b0100);
        step();
        chk_out("fix_load", 1'b1, 4'h7, 2'd2);
        sel = 2'd1;
        #1;
        chk_rdy("fix_nogrant_rdy", 4'b0000);
        step();
        chk_out("fix_pop", 1'b0, 4'h7, 2'd2);
        step();
        chk_out("fix_idle", 1'b0, 4'h7, 2'd2);
        chk_rdy("fix_idle_rdy", 4'b0000);
        in_data = {4'hD, 4'hC, 4'hB, 4'hA};
        in_valid = 4'b0000;

        sel3 = 2'd3; in_valid3 = 3'b111;
        for (int k = 0; k < 4; k++) begin
            #1;
            nvec++;
            if (in_ready3 !== 3'b000) begin
                nerr++;
                $display("FAIL fix3_sel3_rdy actual=%b expected=000", in_ready3);
            end
            step();
            nvec++;
            if (out_valid3 !== 1'b0) begin
                nerr++;
                $display("FAIL fix3_sel3_valid actual=%b expected=0", out_valid3);
            end
        end
        sel3 = 2'd2;
        #1;
        nvec++;
        if (in_ready3 !== 3'b100) begin
            nerr++;
            $display("FAIL fix3_sel2_rdy actual=%b expected=100", in_ready3);
        end
        step();
        nvec++;
        if (out_valid3 !== 1'b1 || mux_out3 !== 4'hC || out_ch3 !== 2'd2) begin
            nerr++;
            $display("FAIL fix3_sel2_out actual v=%b d=%h ch=%0d expected v=1 d=c ch=2",
                     out_valid3, mux_out3, out_ch3);
        end
        in_valid3 = 3'b000;
    endtask

    task automatic test_sparse_wrap();
        mode = 1'b1; in_valid = 4'b1000;
        #1;
        chk_rdy("wrap_rdy3", 4'b1000);
        step();
        chk_out("wrap_g3", 1'b1, 4'hD, 2'd3);
        in_valid = 4'b0010;
        #1;
        chk_rdy("wrap_rdy1", 4'b0010);
        step();
        chk_out("wrap_g1", 1'b1, 4'hB, 2'd1);
        in_valid = 4'b0101;
        #1;
        chk_rdy("wrap_rdy2", 4'b0100);
        step();
        chk_out("wrap_g2", 1'b1, 4'hC, 2'd2);
        chk_rdy("wrap_rdy0", 4'b0001);
        step();
        chk_out("wrap_g0", 1'b1, 4'hA, 2'd0);
    endtask

    task automatic test_reset_mid();
        in_valid = 4'b0100;
        #1;
        step();
        chk_out("mid_g2", 1'b1, 4'hC, 2'd2);
        out_ready = 1'b0; in_valid = 4'b1111;
        #1;
        chk_rdy("mid_stall_rdy", 4'b0000);
        step();
        chk_out("mid_hold", 1'b1, 4'hC, 2'd2);
        reset = 1'b1; out_ready = 1'b1;
        #1;
        chk_rdy("mid_reset_rdy", 4'b0000);
        step();
        chk_out("mid_reset_out", 1'b0, 4'h0, 2'd0);
        reset = 1'b0;
        #1;
        chk_rdy("mid_restart_rdy", 4'b0001);
        for (int k = 0; k < 3; k++) begin
            step();
            chk_out("mid_restart_seq", 1'b1, 4'(4'hA + k), 2'(k));
        end
    endtask

    initial begin
        reset = 1'b1;
        in_data = {4'hD, 4'hC, 4'hB, 4'hA};
        in_valid = 4'b0000; mode = 1'b1; sel = 2'd0; out_ready = 1'b1;
        in_data3 = {4'hC, 4'hB, 4'hA};
        in_valid3 = 3'b000; mode3 = 1'b0; sel3 = 2'd0; out_ready3 = 1'b1;

        test_reset();
        test_round_robin();
        test_backpressure();
        test_fixed();
        test_sparse_wrap();
        test_reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
